// File: rtl/evt_gate_ctrl.sv
// Gated up/down event counter: preload, count evt_in over a timed window, offer frozen result on valid/ready.
// Build option: define EVT_GATE_SYNC_EN to synchronize an asynchronous evt_in and count its rising edges.
module evt_gate_ctrl #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir_up,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              evt_in,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_out,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               dir_r;
  logic [GATE_W-1:0]  len_r;
  logic [GATE_W-1:0]  timer;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   result_r;
  logic               sat_r;
  logic               sat_nxt;
  logic               qev;

  if (SYNC_STAGES < 2) begin : g_bad_sync_depth
    $error("evt_gate_ctrl: SYNC_STAGES must be at least 2");
  end

`ifdef EVT_GATE_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   qev_r;

  // Qualified event is registered after the edge detector: SYNC_STAGES+1 cycles from evt_in rising.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      qev_r     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], evt_in};
      sync_prev <= sync_q[SYNC_STAGES-1];
      qev_r     <= sync_q[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  assign qev = qev_r;
`else
  assign qev = evt_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = ARM;
      ARM:  state_nxt = (len_r == '0) ? HOLD : GATE;
      GATE: if (timer == GATE_W'(1)) state_nxt = HOLD;
      HOLD: if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    result_valid = (state == HOLD);
  end

  // Saturating counter update; an event arriving at the limit only raises sat.
  always_comb begin
    cnt_nxt = cnt;
    sat_nxt = sat_r;
    if (state == IDLE && start) begin
      cnt_nxt = dir_up ? '0 : '1;
      sat_nxt = 1'b0;
    end else if (state == GATE && qev) begin
      if (dir_r) begin
        if (cnt == '1) sat_nxt = 1'b1;
        else           cnt_nxt = cnt + CNT_W'(1);
      end else begin
        if (cnt == '0) sat_nxt = 1'b1;
        else           cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r    <= 1'b0;
      len_r    <= '0;
      timer    <= '0;
      cnt      <= '0;
      sat_r    <= 1'b0;
      result_r <= '0;
    end else begin
      cnt   <= cnt_nxt;
      sat_r <= sat_nxt;
      if (state == IDLE && start) begin
        dir_r <= dir_up;
        len_r <= gate_len;
      end
      if (state == ARM) begin
        timer <= len_r;
      end else if (state == GATE) begin
        timer <= timer - GATE_W'(1);
      end
      // Capture on HOLD entry so the final GATE cycle's event is included.
      if (state != HOLD && state_nxt == HOLD) begin
        result_r <= cnt_nxt;
      end
    end
  end

  assign cnt_out = cnt;
  assign result  = result_r;
  assign sat     = sat_r;

endmodule

// File: tb/tb_evt_gate_ctrl.sv
// Self-checking bench for evt_gate_ctrl: 16-bit and 4-bit instances share stimulus, checked against a counting model.
module tb_evt_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dir_up;
  logic [23:0] gate_len;
  logic        evt_in;
  logic        result_ready;

  logic        busy_a, val_a, sat_a;
  logic [15:0] cnt_a, res_a;
  logic        busy_b, val_b, sat_b;
  logic [3:0]  cnt_b, res_b;

  int checks   = 0;
  int failures = 0;

  evt_gate_ctrl #(.CNT_W(16), .GATE_W(24), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .dir_up(dir_up), .gate_len(gate_len),
    .evt_in(evt_in), .busy(busy_a), .cnt_out(cnt_a), .result(res_a),
    .result_valid(val_a), .result_ready(result_ready), .sat(sat_a)
  );

  evt_gate_ctrl #(.CNT_W(4), .GATE_W(24), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .dir_up(dir_up), .gate_len(gate_len),
    .evt_in(evt_in), .busy(busy_b), .cnt_out(cnt_b), .result(res_b),
    .result_valid(val_b), .result_ready(result_ready), .sat(sat_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counter value after n events from the mode's preload, clamped at the limit.
  function automatic int exp_cnt(input bit up, input int n, input int w);
    int mx = (1 << w) - 1;
    int k  = (n > mx) ? mx : n;
    return up ? k : mx - k;
  endfunction

  function automatic bit exp_sat(input int n, input int w);
    return n > ((1 << w) - 1);
  endfunction

  // pat: 0 random, 1 always high, 2 high for first 4 gate cycles only.
  task automatic measure(input bit up, input int glen, input int pat, input int hold);
    int n = 0;
    bit e;
    @(negedge clk);
    start = 1'b1; dir_up = up; gate_len = 24'(glen);
    @(posedge clk);
    #1;
    start = 1'b0; dir_up = 1'($urandom_range(1, 0)); gate_len = 24'($urandom);
    for (int c = 1; c <= glen + 1; c++) begin
      @(negedge clk);
      chk("busy_run", 32'(busy_a), 32'(1));
      chk("valid_run", 32'(val_a), 32'(0));
      chk("cnt_a_run", 32'(cnt_a), exp_cnt(up, n, 16));
      chk("cnt_b_run", 32'(cnt_b), exp_cnt(up, n, 4));
      chk("sat_b_run", 32'(sat_b), 32'(exp_sat(n, 4)));
      if (c >= 2) begin
        if (pat == 1)      e = 1'b1;
        else if (pat == 2) e = (c - 2) < 4;
        else               e = 1'($urandom_range(1, 0));
        if (e) n++;
      end else begin
        e = 1'($urandom_range(1, 0));
      end
      evt_in = e;
      start  = 1'($urandom_range(1, 0));
    end
    @(negedge clk);
    evt_in = 1'($urandom_range(1, 0));
    chk("valid_hold", 32'(val_a), 32'(1));
    chk("valid_hold_b", 32'(val_b), 32'(1));
    chk("res_a", 32'(res_a), exp_cnt(up, n, 16));
    chk("res_b", 32'(res_b), exp_cnt(up, n, 4));
    chk("sat_a", 32'(sat_a), 32'(exp_sat(n, 16)));
    chk("sat_b", 32'(sat_b), 32'(exp_sat(n, 4)));
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom_range(1, 0));
      evt_in = 1'($urandom_range(1, 0));
      result_ready = 1'b0;
      @(negedge clk);
      chk("valid_stall", 32'(val_a), 32'(1));
      chk("res_stall", 32'(res_a), exp_cnt(up, n, 16));
      chk("cnt_stall", 32'(cnt_b), exp_cnt(up, n, 4));
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    evt_in = 1'b0;
    chk("valid_drop", 32'(val_a), 32'(0));
    chk("busy_idle", 32'(busy_a), 32'(0));
    chk("cnt_keep", 32'(cnt_a), exp_cnt(up, n, 16));
    chk("res_keep", 32'(res_b), exp_cnt(up, n, 4));
  endtask

  task automatic sync_run(input int hi, input int lo, input int reps, input int expn);
    int k;
    @(negedge clk);
    start = 1'b1; dir_up = 1'b1; gate_len = 24'd40;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    for (int r = 0; r < reps; r++) begin
      evt_in = 1'b1;
      repeat (hi) @(negedge clk);
      evt_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
    k = 0;
    while (!val_a && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("sync_valid", 32'(val_a), 32'(1));
    chk("sync_res_a", 32'(res_a), 32'(expn));
    chk("sync_res_b", 32'(res_b), 32'(expn));
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("sync_idle", 32'(busy_a), 32'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir_up = 1'b0; gate_len = '0;
    evt_in = 1'b0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_valid", 32'(val_a), 32'(0));
    chk("rst_cnt", 32'(cnt_a), 32'(0));
    chk("rst_res", 32'(res_a), 32'(0));
    chk("rst_sat", 32'(sat_b), 32'(0));
    rst = 1'b0;

`ifdef EVT_GATE_SYNC_EN
    sync_run(6, 2, 1, 1);
    sync_run(2, 2, 3, 3);
`else
    measure(1'b1, 10, 2, 0);
    chk("up10_result", 32'(res_a), 32'h4);
    measure(1'b0, 5, 1, 1);
    chk("down5_result", 32'(res_a), 32'hFFFA);
    measure(1'b1, 20, 1, 0);
    chk("sat4_flag", 32'(sat_b), 32'(1));
    measure(1'b1, 3, 0, 0);
    measure(1'b1, 0, 0, 5);

    // Reset in the middle of a gate window with three events counted.
    @(negedge clk);
    start = 1'b1; dir_up = 1'b1; gate_len = 24'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      evt_in = (c >= 2);
    end
    @(negedge clk);
    chk("pre_rst_cnt", 32'(cnt_a), 32'(3));
    chk("pre_rst_busy", 32'(busy_a), 32'(1));
    rst = 1'b1;
    evt_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy_a), 32'(0));
    chk("midrst_valid", 32'(val_a), 32'(0));
    chk("midrst_cnt", 32'(cnt_a), 32'(0));
    chk("midrst_res", 32'(res_b), 32'(0));
    measure(1'b0, 7, 0, 2);

    for (int t = 0; t < 8; t++) begin
      measure(1'($urandom_range(1, 0)), int'($urandom_range(25, 0)), 0,
              int'($urandom_range(3, 0)));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
